// File: rtl/calc_pkg.sv
// Shared types and constants for the calculator mailbox.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
// Contents: mbx_state_t controller states, the three accepted operand/opcode
// write addresses, and a helper that recognises them.
package calc_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } mbx_state_t;

    localparam logic [31:0] ADDR_OP1    = 32'd220;
    localparam logic [31:0] ADDR_OP2    = 32'd224;
    localparam logic [31:0] ADDR_OPCODE = 32'd228;

    // True for the only addresses the mailbox forwards to data memory.
    function automatic logic is_mbx_addr(input logic [31:0] addr);
        return (addr == ADDR_OP1) || (addr == ADDR_OP2) || (addr == ADDR_OPCODE);
    endfunction

endpackage

// File: rtl/mbx_fifo.sv
// Generic synchronous FIFO holding pending mailbox writes.
// Latency: dout shows the head entry combinationally; push visible one cycle later.
// Backpressure: push into a full FIFO is ignored unless a pop happens in the same cycle.
// Ports: clk/reset (sync, active-high), push/din, pop/dout, full, empty.
module mbx_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == FULL_CNT);
    assign do_pop  = pop && !empty;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/calc_mailbox.sv
// Mailbox between the calculator front end and the CPU: queues operand writes, drains them to data memory, runs the CPU and captures its result.
// Latency: write edge -> mem_wr_en two cycles later when the memory port is free; run edge -> cpu_run next cycle (empty queue).
// Backpressure: cpu_mem_busy stalls draining; writes arriving at a full queue are dropped and flagged on overflow.
// Ports: hz100 clock, reset (sync, active-high); fpga_wr_* write request; fpga_run_req run request;
// cpu_mem_busy/cpu_done/result_in from the CPU; mem_* write port; cpu_run, result_out/result_valid,
// timeout, overflow, busy status.
// Optional: define CALC_MAILBOX_TIMEOUT_EN to abort runs after RUN_TIMEOUT cycles (sets timeout).
module calc_mailbox
    import calc_pkg::*;
#(
    parameter int FIFO_DEPTH  = 4,
    parameter int RUN_TIMEOUT = 200
) (
    input  logic        hz100,
    input  logic        reset,
    input  logic        fpga_wr_en,
    input  logic [31:0] fpga_wr_addr,
    input  logic [31:0] fpga_wr_data,
    input  logic        fpga_run_req,
    input  logic        cpu_mem_busy,
    input  logic        cpu_done,
    input  logic [31:0] result_in,
    output logic        mem_wr_en,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wr_data,
    output logic        cpu_run,
    output logic [31:0] result_out,
    output logic        result_valid,
    output logic        timeout,
    output logic        overflow,
    output logic        busy
);

    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || RUN_TIMEOUT < 2) begin : g_bad_params
        $error("calc_mailbox: FIFO_DEPTH must be a power of 2 >= 2 and RUN_TIMEOUT >= 2");
    end

    mbx_state_t  state;
    mbx_state_t  next_state;

    logic        wr_en_q;
    logic        run_req_q;
    logic        wr_edge;
    logic        run_edge;
    logic        addr_ok;
    logic        fifo_full;
    logic        fifo_empty;
    logic [63:0] fifo_dout;
    logic        push;
    logic        pop;
    logic        drop;
    logic        enter_clear;
    logic        time_up;

    assign wr_edge  = fpga_wr_en && !wr_en_q;
    assign run_edge = fpga_run_req && !run_req_q;
    assign addr_ok  = is_mbx_addr(fpga_wr_addr);
    assign push     = wr_edge && addr_ok && (!fifo_full || pop);
    assign drop     = wr_edge && addr_ok && fifo_full && !pop;

    mbx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (64)
    ) u_fifo (
        .clk   (hz100),
        .reset (reset),
        .push  (push),
        .din   ({fpga_wr_addr, fpga_wr_data}),
        .pop   (pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // State register.
    always_ff @(posedge hz100) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic.
    always_comb begin
        next_state = state;
        unique case (state)
            IDLE: begin
                if (run_edge) begin
                    next_state = fifo_empty ? RUN : DRAIN;
                end
            end
            DRAIN: begin
                // Wait for the last memory write to leave before starting the CPU.
                if (fifo_empty && !mem_wr_en) begin
                    next_state = RUN;
                end
            end
            RUN: begin
                if (cpu_done || time_up) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                if (!fpga_run_req) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Output / control decode.
    always_comb begin
        pop         = !fifo_empty && !cpu_mem_busy && (state == IDLE || state == DRAIN);
        busy        = (state != IDLE) || !fifo_empty;
        enter_clear = (state != next_state) && (next_state == DRAIN || next_state == RUN);
    end

`ifdef CALC_MAILBOX_TIMEOUT_EN
    localparam int CW = $clog2(RUN_TIMEOUT);

    logic [CW-1:0] run_cnt;

    // Held at zero outside RUN, so every run starts counting from zero.
    always_ff @(posedge hz100) begin
        if (reset || state != RUN) begin
            run_cnt <= '0;
        end else begin
            run_cnt <= run_cnt + 1'b1;
        end
    end

    assign time_up = (state == RUN) && (run_cnt == CW'(RUN_TIMEOUT - 1));

    // cpu_done on the final cycle wins over the abort.
    always_ff @(posedge hz100) begin
        if (reset || enter_clear) begin
            timeout <= 1'b0;
        end else if (time_up && !cpu_done) begin
            timeout <= 1'b1;
        end
    end
`else
    assign time_up = 1'b0;
    assign timeout = 1'b0;
`endif

    always_ff @(posedge hz100) begin
        if (reset) begin
            wr_en_q      <= 1'b0;
            run_req_q    <= 1'b0;
            mem_wr_en    <= 1'b0;
            mem_addr     <= '0;
            mem_wr_data  <= '0;
            cpu_run      <= 1'b0;
            result_out   <= '0;
            result_valid <= 1'b0;
            overflow     <= 1'b0;
        end else begin
            wr_en_q   <= fpga_wr_en;
            run_req_q <= fpga_run_req;

            mem_wr_en <= pop;
            if (pop) begin
                {mem_addr, mem_wr_data} <= fifo_dout;
            end

            // Registered from next_state so cpu_run lines up exactly with RUN.
            cpu_run <= (next_state == RUN);

            if (enter_clear) begin
                result_valid <= 1'b0;
            end else if (state == RUN && cpu_done) begin
                result_out   <= result_in;
                result_valid <= 1'b1;
            end

            // A drop in the same cycle as a run edge stays visible.
            if (drop) begin
                overflow <= 1'b1;
            end else if (run_edge) begin
                overflow <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_calc_mailbox.sv
// Self-checking bench for calc_mailbox: directed scenario sequence with random data,
// compared against a queue-based model of accepted/drained writes and captured results.
module tb_calc_mailbox;
    localparam int DEPTH = 4;
    localparam int TMO   = 200;

    logic        hz100 = 1'b0;
    logic        reset = 1'b1;
    logic        fpga_wr_en = 1'b0;
    logic [31:0] fpga_wr_addr = '0;
    logic [31:0] fpga_wr_data = '0;
    logic        fpga_run_req = 1'b0;
    logic        cpu_mem_busy = 1'b0;
    logic        cpu_done = 1'b0;
    logic [31:0] result_in = '0;

    logic        mem_wr_en;
    logic [31:0] mem_addr;
    logic [31:0] mem_wr_data;
    logic        cpu_run;
    logic [31:0] result_out;
    logic        result_valid;
    logic        timeout;
    logic        overflow;
    logic        busy;

    calc_mailbox #(
        .FIFO_DEPTH  (DEPTH),
        .RUN_TIMEOUT (TMO)
    ) dut (
        .hz100        (hz100),
        .reset        (reset),
        .fpga_wr_en   (fpga_wr_en),
        .fpga_wr_addr (fpga_wr_addr),
        .fpga_wr_data (fpga_wr_data),
        .fpga_run_req (fpga_run_req),
        .cpu_mem_busy (cpu_mem_busy),
        .cpu_done     (cpu_done),
        .result_in    (result_in),
        .mem_wr_en    (mem_wr_en),
        .mem_addr     (mem_addr),
        .mem_wr_data  (mem_wr_data),
        .cpu_run      (cpu_run),
        .result_out   (result_out),
        .result_valid (result_valid),
        .timeout      (timeout),
        .overflow     (overflow),
        .busy         (busy)
    );

    always #5 hz100 = ~hz100;

    int checks = 0;
    int errors = 0;

    // Model: pend_q = writes accepted but not yet allowed to drain,
    // done_q = writes that must have appeared on the memory port, in order.
    logic [63:0] obs_q[$];
    logic [63:0] pend_q[$];
    logic [63:0] done_q[$];
    logic        m_ovf = 1'b0;
    logic [31:0] m_result = '0;
    logic [31:0] valid_addrs [3] = '{32'd220, 32'd224, 32'd228};

    always @(negedge hz100) begin
        if (mem_wr_en === 1'b1) begin
            obs_q.push_back({mem_addr, mem_wr_data});
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge hz100);
        #1;
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input int hold);
        fpga_wr_addr = a;
        fpga_wr_data = d;
        fpga_wr_en   = 1'b1;
        tick();
        repeat (hold) tick();
        fpga_wr_en = 1'b0;
        tick();
        if (a == 32'd220 || a == 32'd224 || a == 32'd228) begin
            if (pend_q.size() < DEPTH) pend_q.push_back({a, d});
            else m_ovf = 1'b1;
        end
    endtask

    task automatic model_drain();
        while (pend_q.size() > 0) done_q.push_back(pend_q.pop_front());
    endtask

    task automatic compare_writes(input string tag);
        check({tag, "_count"}, 64'(obs_q.size()), 64'(done_q.size()));
        for (int i = 0; i < obs_q.size() && i < done_q.size(); i++) begin
            check($sformatf("%s_entry%0d", tag, i), obs_q[i], done_q[i]);
        end
    endtask

    task automatic wait_run(input int bound, input string tag);
        int n = 0;
        while (cpu_run !== 1'b1 && n < bound) begin
            tick();
            n++;
        end
        check(tag, 64'(cpu_run), 64'd1);
    endtask

    task automatic finish_run(input int cycles, input logic [31:0] res, input string tag);
        repeat (cycles) tick();
        cpu_done  = 1'b1;
        result_in = res;
        tick();
        cpu_done = 1'b0;
        m_result = res;
        check({tag, "_result_out"}, 64'(result_out), 64'(m_result));
        check({tag, "_result_valid"}, 64'(result_valid), 64'd1);
        check({tag, "_cpu_run_low"}, 64'(cpu_run), 64'd0);
        check({tag, "_timeout_low"}, 64'(timeout), 64'd0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [31:0] d;
        int n;

        // Reset state.
        repeat (2) tick();
        reset = 1'b0;
        tick();
        check("rst_mem_wr_en", 64'(mem_wr_en), 64'd0);
        check("rst_cpu_run", 64'(cpu_run), 64'd0);
        check("rst_result_out", 64'(result_out), 64'd0);
        check("rst_result_valid", 64'(result_valid), 64'd0);
        check("rst_timeout", 64'(timeout), 64'd0);
        check("rst_overflow", 64'(overflow), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);

        // Three operand writes drained in arrival order while idle; one held level.
        do_write(32'd220, 32'd12, 0); model_drain();
        do_write(32'd228, 32'd8, 3);  model_drain();
        do_write(32'd224, 32'd7, 0);  model_drain();
        repeat (3) tick();
        compare_writes("idle_drain");
        check("idle_busy", 64'(busy), 64'd0);

        // Run from an empty queue goes straight to RUN.
        fpga_run_req = 1'b1;
        wait_run(5, "run_start");
        check("run_busy", 64'(busy), 64'd1);
        // Write during RUN is queued but held until RUN ends.
        d = $urandom;
        do_write(32'd224, d, 0);
        repeat (3) tick();
        compare_writes("run_hold");
        finish_run(5, 32'd84, "done84");
        fpga_run_req = 1'b0;
        model_drain();
        repeat (4) tick();
        compare_writes("after_run_drain");

        // Unmapped address is discarded.
        do_write(32'd244, $urandom, 0);
        repeat (3) tick();
        compare_writes("addr244");
        check("addr244_busy", 64'(busy), 64'd0);

        // Five writes with the memory port busy: four queued, fifth dropped.
        cpu_mem_busy = 1'b1;
        for (int i = 0; i < 5; i++) begin
            do_write(valid_addrs[$urandom_range(2)], $urandom, 0);
        end
        check("ovf_set", 64'(overflow), 64'(m_ovf));
        check("ovf_busy", 64'(busy), 64'd1);
        // Run edge with a non-empty queue: DRAIN, overflow cleared.
        fpga_run_req = 1'b1;
        tick();
        m_ovf = 1'b0;
        check("ovf_clear", 64'(overflow), 64'(m_ovf));
        repeat (3) tick();
        check("drain_stall_cpu_run", 64'(cpu_run), 64'd0);
        compare_writes("drain_stalled");
        cpu_mem_busy = 1'b0;
        model_drain();
        wait_run(20, "drain_then_run");
        compare_writes("drain_done");
        finish_run($urandom_range(1, 20), $urandom, "rand_done");
        fpga_run_req = 1'b0;
        repeat (2) tick();

        // Run without cpu_done.
        fpga_run_req = 1'b1;
        wait_run(5, "tmo_run_start");
        check("tmo_valid_cleared", 64'(result_valid), 64'd0);
`ifdef CALC_MAILBOX_TIMEOUT_EN
        n = 0;
        while (timeout !== 1'b1 && n < TMO + 100) begin
            tick();
            n++;
        end
        check("tmo_flag", 64'(timeout), 64'd1);
        check("tmo_cycles", 64'(n), 64'(TMO));
        check("tmo_result_kept", 64'(result_out), 64'(m_result));
        check("tmo_valid_low", 64'(result_valid), 64'd0);
        check("tmo_cpu_run_low", 64'(cpu_run), 64'd0);
`else
        n = TMO + 50;
        repeat (n) tick();
        check("notmo_still_run", 64'(cpu_run), 64'd1);
        check("notmo_timeout_low", 64'(timeout), 64'd0);
        finish_run(0, $urandom, "notmo_done");
`endif
        // cpu_done outside RUN is ignored.
        cpu_done  = 1'b1;
        result_in = ~m_result;
        repeat (2) tick();
        cpu_done = 1'b0;
        check("done_outside_run", 64'(result_out), 64'(m_result));
        fpga_run_req = 1'b0;
        repeat (2) tick();

        // Reset in the middle of a run, with a pending write in the queue.
        fpga_run_req = 1'b1;
        wait_run(5, "rst_run_start");
        cpu_mem_busy = 1'b1;
        do_write(32'd220, $urandom, 0);
        repeat (2) tick();
        reset = 1'b1;
        fpga_run_req = 1'b0;
        tick();
        pend_q.delete();
        m_result = '0;
        m_ovf = 1'b0;
        check("midrst_cpu_run", 64'(cpu_run), 64'd0);
        check("midrst_result_out", 64'(result_out), 64'(m_result));
        check("midrst_result_valid", 64'(result_valid), 64'd0);
        check("midrst_mem_wr_en", 64'(mem_wr_en), 64'd0);
        check("midrst_overflow", 64'(overflow), 64'(m_ovf));
        check("midrst_timeout", 64'(timeout), 64'd0);
        check("midrst_busy", 64'(busy), 64'd0);
        reset = 1'b0;
        cpu_mem_busy = 1'b0;
        repeat (5) tick();
        compare_writes("midrst_queue_flushed");
        check("midrst_idle_cpu_run", 64'(cpu_run), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
